// File: rtl/ptp_pulse_gen.sv
// ptp_pulse_gen: periodic pulse generator slaved to the PTP time-of-day bus.
// Rising edges land at start + n*period; each pulse stays high for width.
// A clock step or a new start/period re-arms the schedule.
// Optional build macro PTP_PULSE_GEN_OUT_REG_EN adds one output flop on
// output_pulse and locked (IOB-friendly, latency 2 clk instead of 1).
//
// state       | meaning
// S_IDLE      | output off, waiting for enable and a legal configuration
// S_ARM       | load next_rise from the start time
// S_CATCHUP   | step next_rise by one period per cycle until it is in the future
// S_WAIT_RISE | output low, waiting for ts >= next_rise
// S_WAIT_FALL | output high, waiting for ts >= next_fall
module ptp_pulse_gen #(
  parameter logic [29:0] NS_PER_S      = 30'd1_000_000_000,
  parameter logic [47:0] OUT_START_S   = 48'h0,
  parameter logic [29:0] OUT_START_NS  = 30'h0,
  parameter logic [47:0] OUT_PERIOD_S  = 48'h1,
  parameter logic [29:0] OUT_PERIOD_NS = 30'h0,
  parameter logic [47:0] OUT_WIDTH_S   = 48'h0,
  parameter logic [29:0] OUT_WIDTH_NS  = 30'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] input_ts_96,
  input  logic        input_ts_step,
  input  logic        enable,
  input  logic [95:0] input_start,
  input  logic        input_start_valid,
  input  logic [95:0] input_period,
  input  logic        input_period_valid,
  input  logic [95:0] input_width,
  input  logic        input_width_valid,
  output logic        locked,
  output logic        error,
  output logic        output_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CATCHUP,
    S_WAIT_RISE,
    S_WAIT_FALL
  } state_t;

  // Times are {s[47:0], ns[29:0]}; with ns < NS_PER_S the 78-bit unsigned
  // compare of the concatenation orders times correctly.
  function automatic logic [77:0] f_add(input logic [77:0] a, input logic [77:0] b);
    logic [30:0] ns_sum;
    logic [47:0] s_sum;
    ns_sum = {1'b0, a[29:0]} + {1'b0, b[29:0]};
    s_sum  = a[77:30] + b[77:30];
    if (ns_sum >= {1'b0, NS_PER_S}) begin
      ns_sum = ns_sum - {1'b0, NS_PER_S};
      s_sum  = s_sum + 48'd1;
    end
    return {s_sum, ns_sum[29:0]};
  endfunction

  state_t      r_state;
  logic [77:0] r_start;
  logic [77:0] r_period;
  logic [77:0] r_width;
  logic [77:0] r_next_rise;
  logic [77:0] r_next_fall;
  logic        r_pulse;
  logic        r_locked;
  logic        r_error;

  logic [77:0] w_ts;
  logic [77:0] w_in_start;
  logic [77:0] w_in_period;
  logic [77:0] w_in_width;
  logic        w_start_bad;
  logic        w_period_bad;
  logic        w_width_bad;
  logic        w_load_err;
  logic        w_cfg_legal;
  logic        w_rearm;
  logic        w_ge_rise;
  logic        w_ge_fall;
  logic [77:0] w_rise_plus_period;
  logic [77:0] w_rise_plus_width;
  logic        w_unused;

  // The fractional-ns field and the two pad bits carry nothing we use.
  assign w_unused = ^{input_ts_96[47:46], input_ts_96[15:0],
                      input_start[47:46], input_start[15:0],
                      input_period[47:46], input_period[15:0],
                      input_width[47:46], input_width[15:0]};

  assign w_ts        = {input_ts_96[95:48], input_ts_96[45:16]};
  assign w_in_start  = {input_start[95:48], input_start[45:16]};
  assign w_in_period = {input_period[95:48], input_period[45:16]};
  assign w_in_width  = {input_width[95:48], input_width[45:16]};

  assign w_start_bad  = input_start_valid  && (w_in_start[29:0]  >= NS_PER_S);
  assign w_period_bad = input_period_valid && (w_in_period[29:0] >= NS_PER_S);
  assign w_width_bad  = input_width_valid  && (w_in_width[29:0]  >= NS_PER_S);
  assign w_load_err   = w_start_bad || w_period_bad || w_width_bad;

  assign w_cfg_legal = (r_period != 78'd0) && (r_width < r_period);
  assign w_rearm     = input_ts_step || input_start_valid || input_period_valid;

  assign w_ge_rise          = (w_ts >= r_next_rise);
  assign w_ge_fall          = (w_ts >= r_next_fall);
  assign w_rise_plus_period = f_add(r_next_rise, r_period);
  assign w_rise_plus_width  = f_add(r_next_rise, r_width);

  // Configuration registers; a value with an out-of-range ns field is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start  <= {OUT_START_S, OUT_START_NS};
      r_period <= {OUT_PERIOD_S, OUT_PERIOD_NS};
      r_width  <= {OUT_WIDTH_S, OUT_WIDTH_NS};
    end else begin
      if (input_start_valid && !w_start_bad)
        r_start <= w_in_start;
      if (input_period_valid && !w_period_bad)
        r_period <= w_in_period;
      if (input_width_valid && !w_width_bad)
        r_width <= w_in_width;
    end
  end

  // Sticky error: any rejected load or an illegal period/width pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_error <= 1'b0;
    else if (w_load_err || !w_cfg_legal)
      r_error <= 1'b1;
  end

  // Pulse scheduler; disable and illegal config win over re-arm, re-arm over stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_next_rise <= '0;
      r_next_fall <= '0;
      r_pulse     <= 1'b0;
      r_locked    <= 1'b0;
    end else if (!enable || !w_cfg_legal) begin
      r_state  <= S_IDLE;
      r_pulse  <= 1'b0;
      r_locked <= 1'b0;
    end else if (w_rearm) begin
      r_state  <= S_ARM;
      r_pulse  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pulse  <= 1'b0;
          r_locked <= 1'b0;
          r_state  <= S_ARM;
        end
        S_ARM: begin
          r_next_rise <= r_start;
          r_state     <= S_CATCHUP;
        end
        S_CATCHUP: begin
          if (w_ge_rise) begin
            r_next_rise <= w_rise_plus_period;
          end else begin
            r_next_fall <= w_rise_plus_width;
            r_locked    <= 1'b1;
            r_state     <= S_WAIT_RISE;
          end
        end
        S_WAIT_RISE: begin
          if (w_ge_rise) begin
            r_pulse     <= 1'b1;
            r_next_rise <= w_rise_plus_period;
            r_state     <= S_WAIT_FALL;
          end
        end
        S_WAIT_FALL: begin
          // next_rise already moved on at the rising edge, so this is the next pulse's fall.
          if (w_ge_fall) begin
            r_pulse     <= 1'b0;
            r_next_fall <= w_rise_plus_width;
            r_state     <= S_WAIT_RISE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_pulse  <= 1'b0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef PTP_PULSE_GEN_OUT_REG_EN
  logic r_pulse_q;
  logic r_locked_q;

  // Extra output stage so the pins can be driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse_q  <= 1'b0;
      r_locked_q <= 1'b0;
    end else begin
      r_pulse_q  <= r_pulse;
      r_locked_q <= r_locked;
    end
  end

  assign output_pulse = r_pulse_q;
  assign locked       = r_locked_q;
`else
  assign output_pulse = r_pulse;
  assign locked       = r_locked;
`endif

  assign error = r_error;

endmodule

// File: tb/tb_ptp_pulse_gen.sv
// Bench for ptp_pulse_gen: expected pulse edges (level + ToD that triggered
// them) are queued by the stimulus; a negedge monitor pops and checks them.
module tb_ptp_pulse_gen;

  localparam logic [29:0] NSPS = 30'd1_000_000_000;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ts_s;
  logic [29:0] ts_ns;
  logic [95:0] ts_96;
  logic        ts_step;
  logic        enable;
  logic [95:0] start_v, period_v, width_v;
  logic        start_valid, period_valid, width_valid;
  logic        locked, error, output_pulse;

  typedef struct packed {
    logic        level;
    logic [77:0] t;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  last_hi = 0;

  assign ts_96 = {ts_s, 2'b00, ts_ns, 16'h0};

  always #5 clk = ~clk;

  ptp_pulse_gen dut (
    .clk                (clk),
    .rst                (rst),
    .input_ts_96        (ts_96),
    .input_ts_step      (ts_step),
    .enable             (enable),
    .input_start        (start_v),
    .input_start_valid  (start_valid),
    .input_period       (period_v),
    .input_period_valid (period_valid),
    .input_width        (width_v),
    .input_width_valid  (width_valid),
    .locked             (locked),
    .error              (error),
    .output_pulse       (output_pulse)
  );

  function automatic logic [95:0] mk(input logic [47:0] s, input logic [29:0] ns);
    return {s, 2'b00, ns, 16'h0};
  endfunction

  function automatic logic [77:0] tv(input logic [47:0] s, input logic [29:0] ns);
    return {s, ns};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic level, input logic [47:0] s, input logic [29:0] ns);
    ev_t e;
    e.level = level;
    e.t     = tv(s, ns);
    exp_q.push_back(e);
  endtask

  // One clock; ToD advances 8 ns per clk just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ts_ns + 30'd8 >= NSPS) begin
      ts_ns = ts_ns + 30'd8 - NSPS;
      ts_s  = ts_s + 48'd1;
    end else begin
      ts_ns = ts_ns + 30'd8;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle();
`ifdef PTP_PULSE_GEN_OUT_REG_EN
    tick();
`endif
  endtask

  task automatic wait_pulse(input logic val, input int max_cyc, input string name);
    int k;
    k = 0;
    while (output_pulse !== val && k < max_cyc) begin
      tick();
      k++;
    end
    n_tests++;
    if (output_pulse !== val) begin
      n_fail++;
      $display("FAIL %s: output_pulse still %0b after %0d clk, expected %0b", name, output_pulse, k, val);
    end
  endtask

  task automatic wait_locked(input int max_cyc, output int cnt);
    cnt = 0;
    while (locked !== 1'b1 && cnt < max_cyc) begin
      tick();
      cnt++;
    end
  endtask

  // Monitor: every output edge must match the head of the queue, both in
  // level and in the ToD sampled on the edge that caused it.
  initial begin : monitor
    logic        prev;
    logic [77:0] h1, h2, samp;
    int          hi_cnt;
    ev_t         e;
    prev   = 1'b0;
    h1     = '0;
    h2     = '0;
    hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev = 1'b0;
        h1   = tv(ts_s, ts_ns);
        h2   = h1;
      end else begin
        if (output_pulse !== prev) begin
`ifdef PTP_PULSE_GEN_OUT_REG_EN
          samp = h2;
`else
          samp = h1;
`endif
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_edge: output_pulse went %0b at ts s=%0d ns=%0d, expected no edge",
                     output_pulse, samp[77:30], samp[29:0]);
          end else begin
            e = exp_q.pop_front();
            if (e.level !== output_pulse || e.t !== samp) begin
              n_fail++;
              $display("FAIL edge: got level %0b at s=%0d ns=%0d, expected level %0b at s=%0d ns=%0d",
                       output_pulse, samp[77:30], samp[29:0], e.level, e.t[77:30], e.t[29:0]);
            end
          end
          if (output_pulse === 1'b1) hi_cnt = 0;
          else last_hi = hi_cnt;
        end
        if (output_pulse === 1'b1) hi_cnt++;
        prev = output_pulse;
        h2   = h1;
        h1   = tv(ts_s, ts_ns);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    rst          = 1'b1;
    enable       = 1'b0;
    ts_step      = 1'b0;
    ts_s         = '0;
    ts_ns        = '0;
    start_v      = '0;
    period_v     = '0;
    width_v      = '0;
    start_valid  = 1'b0;
    period_valid = 1'b0;
    width_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulse", 64'(output_pulse), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    rst = 1'b0;

    // Test 1: defaults (start 0, period 1 s, width 1000 ns)
    enable = 1'b1;
    run(8);
    chk("t1_locked", 64'(locked), 64'd1);
    chk("t1_pulse_low", 64'(output_pulse), 64'd0);
    push(1'b1, 48'd1, 30'd0);
    push(1'b0, 48'd1, 30'd1000);
    ts_s = 48'd0; ts_ns = 30'd999_999_920;
    run(150);
    push(1'b1, 48'd2, 30'd0);
    push(1'b0, 48'd2, 30'd1000);
    ts_s = 48'd1; ts_ns = 30'd999_999_920;
    run(150);
    chk("t1_queue_drained", 64'(exp_q.size()), 64'd0);

    enable = 1'b0;
    tick();
    settle();
    chk("disable_locked", 64'(locked), 64'd0);
    enable = 1'b1;

    // Test 2: fall time crosses a second boundary
    start_v     = mk(48'd5, 30'd999_999_990);
    width_v     = mk(48'd0, 30'd20);
    start_valid = 1'b1;
    width_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    width_valid = 1'b0;
    run(6);
    chk("t2_locked", 64'(locked), 64'd1);
    push(1'b1, 48'd5, 30'd999_999_992);
    push(1'b0, 48'd6, 30'd16);
    ts_s = 48'd5; ts_ns = 30'd999_999_960;
    run(20);
    chk("t2_high_clks", 64'(last_hi), 64'd3);
    chk("t2_queue_drained", 64'(exp_q.size()), 64'd0);

    // Test 4: clock step while the pulse is high
    push(1'b1, 48'd6, 30'd999_999_992);
    ts_s = 48'd6; ts_ns = 30'd999_999_960;
    wait_pulse(1'b1, 20, "t4_rise");
    push(1'b0, ts_s, ts_ns);
    ts_step = 1'b1;
    tick();
    ts_step = 1'b0;
    settle();
    chk("t4_pulse_dropped", 64'(output_pulse), 64'd0);
    chk("t4_locked_dropped", 64'(locked), 64'd0);
    run(8);
    chk("t4_relocked", 64'(locked), 64'd1);

    // Test 3: step to s=1000 with start 0, period 1 s
    start_v      = mk(48'd0, 30'd0);
    period_v     = mk(48'd1, 30'd0);
    width_v      = mk(48'd0, 30'd1000);
    start_valid  = 1'b1;
    period_valid = 1'b1;
    width_valid  = 1'b1;
    ts_step      = 1'b1;
    ts_s = 48'd1000; ts_ns = 30'd0;
    tick();
    start_valid  = 1'b0;
    period_valid = 1'b0;
    width_valid  = 1'b0;
    ts_step      = 1'b0;
    chk("t3_locked_dropped", 64'(locked), 64'd0);
    wait_locked(1100, cnt);
    n_tests++;
    if (cnt < 1000 || cnt > 1010) begin
      n_fail++;
      $display("FAIL t3_catchup_cycles: got %0d, expected 1000..1010", cnt);
    end
    push(1'b1, 48'd1001, 30'd0);
    push(1'b0, 48'd1001, 30'd1000);
    ts_s = 48'd1000; ts_ns = 30'd999_999_920;
    run(150);
    chk("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // Test 5: illegal period ns, then width >= period
    chk("t5_error_clear", 64'(error), 64'd0);
    period_v     = mk(48'd1, NSPS);
    period_valid = 1'b1;
    tick();
    period_valid = 1'b0;
    chk("t5_error_bad_ns", 64'(error), 64'd1);
    width_v     = mk(48'd2, 30'd0);
    width_valid = 1'b1;
    tick();
    width_valid = 1'b0;
    run(3);
    chk("t5_idle_locked", 64'(locked), 64'd0);
    chk("t5_idle_error", 64'(error), 64'd1);
    ts_s = 48'd1001; ts_ns = 30'd999_999_920;
    run(20);
    chk("t5_idle_pulse", 64'(output_pulse), 64'd0);
    period_v     = mk(48'd3, 30'd0);
    period_valid = 1'b1;
    tick();
    period_valid = 1'b0;
    wait_locked(500, cnt);
    chk("t5_resume_locked", 64'(locked), 64'd1);
    chk("t5_error_sticky", 64'(error), 64'd1);
    push(1'b1, 48'd1005, 30'd0);
    ts_s = 48'd1004; ts_ns = 30'd999_999_920;
    wait_pulse(1'b1, 30, "t5_rise");
    tick();
    chk("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // Test 6: asynchronous reset mid-pulse
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_pulse", 64'(output_pulse), 64'd0);
    chk("t6_async_locked", 64'(locked), 64'd0);
    chk("t6_async_error", 64'(error), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_locked(1100, cnt);
    chk("t6_relocked", 64'(locked), 64'd1);
    push(1'b1, 48'd1006, 30'd0);
    push(1'b0, 48'd1006, 30'd1000);
    ts_s = 48'd1005; ts_ns = 30'd999_999_920;
    run(150);

    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
